star_reveal_ctrl: RTL and testbench
===================================

# star_reveal_ctrl

Sequencer for the win-screen star display. On a start request it latches the three-bit coin status from game logic and counts collected coins. It then lights the score stars one at a time, left to right, pacing each reveal in whole video frames. Its `star_mask` output drives the star renderer's per-star lit/unlit sprite selection, replacing the direct count decode, and its `reveal_pulse` output feeds the sound/effects logic.

## Interface
Parameters:
- `INITIAL_DELAY`, default 15: frame ticks from start until the first reveal decision; legal range 1..255.
- `FRAMES_PER_STAR`, default 30: frame ticks between successive star reveals; legal range 1..255.

Ports:
- `Clk`, input, 1: 50 MHz system clock.
- `Reset`, input, 1: asynchronous, active-high reset.
- `frame_tick`, input, 1: one-cycle pulse per video frame (vsync edge, generated elsewhere).
- `start`, input, 1: one-cycle request to begin the reveal sequence.
- `clear`, input, 1: one-cycle request to abort and return to idle.
- `CoinStatus`, input, 3: per-coin status from game logic; bit = 0 means the coin was collected.
- `star_mask`, output, 3: bit i = 1 means star i+1 is drawn lit; bit 0 is the leftmost star.
- `stars_total`, output, 2: number of collected coins, latched at start (0..3).
- `reveal_pulse`, output, 1: one-cycle pulse in the cycle a `star_mask` bit is set.
- `busy`, output, 1: high while in `WAIT_INIT` or `REVEAL`.
- `done`, output, 1: high in `DONE`.

## Operation
- States: `IDLE`, `WAIT_INIT`, `REVEAL`, `DONE`. Outputs are registered.
- Internal frame counter `fcnt`: 8 bits, counts `frame_tick` pulses only, and is cleared on every state entry.
- `IDLE`:
  - `star_mask` = 0, `stars_total` = 0.
  - On `start`: latch `stars_total` = number of zero bits in `CoinStatus`, clear `fcnt`, go to `WAIT_INIT`.
- `WAIT_INIT`:
  - On `frame_tick` with `fcnt` = `INITIAL_DELAY`-1: if `stars_total` = 0, go to `DONE` with no reveal.
  - Otherwise set `star_mask[0]`, pulse `reveal_pulse`, and go to `DONE` if `stars_total` = 1, else to `REVEAL`.
  - On any other `frame_tick`: `fcnt`++.
- `REVEAL`:
  - On `frame_tick` with `fcnt` = `FRAMES_PER_STAR`-1: set the next mask bit (thermometer order: 001, 011, 111) and pulse `reveal_pulse`.
  - If the number of lit bits now equals `stars_total`, go to `DONE`; else clear `fcnt` and stay in `REVEAL`.
- `DONE`: hold `star_mask` and `stars_total`. `start` restarts: clear the mask, re-latch `CoinStatus`, go to `WAIT_INIT`.
- `start` is ignored while `busy` = 1.
- `CoinStatus` changes after the latch have no effect.
- `clear` in any state: go to `IDLE`, zero all outputs. `clear` has priority over a simultaneous `start` or `frame_tick`.
- Invariants:
  - `star_mask` is always thermometer coded.
  - `popcount(star_mask)` ≤ `stars_total`.

## Timing
- Reset (asynchronous): state = `IDLE`; `star_mask` = 000, `stars_total` = 0, `reveal_pulse` = 0, `busy` = 0, `done` = 0, `fcnt` = 0.
- `start` sampled at edge t: `busy` = 1 and `stars_total` valid from t+1.
- Reveal latency: the k-th `star_mask` bit and `reveal_pulse` appear the cycle after the edge that samples the matching `frame_tick`.
  - The first reveal falls on the `INITIAL_DELAY`-th tick after start.
  - Each following reveal falls `FRAMES_PER_STAR` ticks after the previous one.
- A `frame_tick` in the same cycle as an accepted `start` is not counted.
- `done` rises in the same cycle as the final reveal, or after `INITIAL_DELAY` ticks when `stars_total` = 0. `busy` falls in that same cycle.
- `reveal_pulse` is exactly one cycle wide; there is never more than one reveal per `frame_tick`.
- `clear` sampled at edge t: all outputs zero at t+1.

## Test plan
Bench parameters: `INITIAL_DELAY`=2, `FRAMES_PER_STAR`=3, `frame_tick` every 10 cycles.

- Reset mid-sequence: assert `Reset` asynchronously while `star_mask`=001 -> all outputs 0 immediately, without waiting for a `Clk` edge. After release, state is `IDLE`.
- Three coins collected: `CoinStatus`=000, `start` -> `stars_total`=3, and `star_mask` goes 001 at tick 2, 011 at tick 5, 111 at tick 8.
  - Three `reveal_pulse` pulses, each one cycle wide.
  - `done`=1 and `busy`=0 in the cycle `star_mask`=111.
- One coin collected: `CoinStatus`=101, `start` -> `stars_total`=1, `star_mask`=001 at tick 2, `done` in the same cycle; no further changes on later ticks.
- No coins: `CoinStatus`=111, `start` -> `done`=1 after tick 2, `star_mask` stays 000, no `reveal_pulse`.
- Busy and latch behaviour: with `CoinStatus`=000, pulse `start` again at tick 3 and change `CoinStatus` to 111 at tick 4 -> sequence unchanged, ending at `star_mask`=111.
- Clear and restart:
  - `clear` and `start` in the same cycle while `star_mask`=011 -> `IDLE`, all outputs 0.
  - A later `start` with `CoinStatus`=110 -> `stars_total`=1, `star_mask`=001 at tick 2.
  - A `start` from `DONE` restarts with the mask cleared.

Source files
------------

// File: rtl/star_reveal_ctrl_if.sv
// Bus bundle between game logic and the win-screen star reveal sequencer.
// The master drives requests and coin status; the slave (sequencer) drives the display outputs.
interface star_reveal_ctrl_if;
  logic       frame_tick;
  logic       start;
  logic       clear;
  logic [2:0] CoinStatus;
  logic [2:0] star_mask;
  logic [1:0] stars_total;
  logic       reveal_pulse;
  logic       busy;
  logic       done;

  modport master (
    output frame_tick, start, clear, CoinStatus,
    input  star_mask, stars_total, reveal_pulse, busy, done
  );

  modport slave (
    input  frame_tick, start, clear, CoinStatus,
    output star_mask, stars_total, reveal_pulse, busy, done
  );
endinterface

// File: rtl/star_reveal_ctrl.sv
// Win-screen star reveal sequencer: latches the collected-coin count on start and
// lights the stars left to right, pacing each reveal in whole video frames.
module star_reveal_ctrl #(
  parameter int INITIAL_DELAY   = 15,
  parameter int FRAMES_PER_STAR = 30
) (
  input  logic              Clk,
  input  logic              Reset,
  star_reveal_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_INIT = 2'd1,
    REVEAL    = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [7:0] INIT_LAST = 8'(INITIAL_DELAY - 1);
  localparam logic [7:0] STAR_LAST = 8'(FRAMES_PER_STAR - 1);

  state_t     state, state_n;
  logic [7:0] fcnt, fcnt_n;
  logic [2:0] mask_q, mask_n;
  logic [1:0] total_q, total_n;
  logic       pulse_q, pulse_n;
  logic       busy_q, busy_n;
  logic       done_q, done_n;
  logic [1:0] coins_collected;
  logic [1:0] lit_next;

  function automatic logic [1:0] ones3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  // A zero bit in CoinStatus marks a collected coin.
  assign coins_collected = ones3(~bus.CoinStatus);
  assign lit_next        = ones3(mask_n);

  // NOTE: every variable written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    mask_n  = mask_q;
    total_n = total_q;
    pulse_n = 1'b0;

    if (bus.clear) begin
      state_n = IDLE;
      fcnt_n  = '0;
      mask_n  = '0;
      total_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          mask_n  = '0;
          total_n = '0;
          if (bus.start) begin
            total_n = coins_collected;
            fcnt_n  = '0;
            state_n = WAIT_INIT;
          end
        end

        WAIT_INIT: begin
          if (bus.frame_tick) begin
            if (fcnt == INIT_LAST) begin
              fcnt_n = '0;
              if (total_q == 2'd0) begin
                state_n = DONE;
              end else begin
                mask_n  = 3'b001;
                pulse_n = 1'b1;
                state_n = (total_q == 2'd1) ? DONE : REVEAL;
              end
            end else begin
              fcnt_n = fcnt + 8'd1;
            end
          end
        end

        REVEAL: begin
          if (bus.frame_tick) begin
            if (fcnt == STAR_LAST) begin
              // Shift in a one to keep the mask thermometer coded.
              mask_n  = {mask_q[1:0], 1'b1};
              pulse_n = 1'b1;
              fcnt_n  = '0;
              if (lit_next == total_q) state_n = DONE;
            end else begin
              fcnt_n = fcnt + 8'd1;
            end
          end
        end

        DONE: begin
          if (bus.start) begin
            mask_n  = '0;
            total_n = coins_collected;
            fcnt_n  = '0;
            state_n = WAIT_INIT;
          end
        end

        default: state_n = IDLE;
      endcase
    end

    busy_n = (state_n == WAIT_INIT) || (state_n == REVEAL);
    done_n = (state_n == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      fcnt    <= '0;
      mask_q  <= '0;
      total_q <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      fcnt    <= fcnt_n;
      mask_q  <= mask_n;
      total_q <= total_n;
      pulse_q <= pulse_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  assign bus.star_mask    = mask_q;
  assign bus.stars_total  = total_q;
  assign bus.reveal_pulse = pulse_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_star_reveal_ctrl.sv
// Self-checking bench for star_reveal_ctrl: directed scenarios with literal
// expectations plus a per-cycle comparison against a frame-count model.
module tb_star_reveal_ctrl;

  localparam int INIT = 2;
  localparam int FPS  = 3;

  logic Clk = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   pulse_cnt = 0;
  bit   chk_en = 1'b0;

  star_reveal_ctrl_if bus ();

  star_reveal_ctrl #(
    .INITIAL_DELAY  (INIT),
    .FRAMES_PER_STAR(FPS)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is described only by how many frame ticks have elapsed since
  // start; the number of lit stars follows from the pacing rules directly.
  bit m_active;
  int m_total;
  int m_ticks;
  bit m_pulse;

  function automatic int lit_of(input int ticks, input int total);
    int l;
    if (ticks < INIT) return 0;
    l = 1 + (ticks - INIT) / FPS;
    return (l > total) ? total : l;
  endfunction

  function automatic bit fin_of(input bit active, input int ticks, input int total);
    return active && ticks >= INIT && lit_of(ticks, total) == total;
  endfunction

  function automatic int zeros_of(input logic [2:0] v);
    int z = 0;
    for (int i = 0; i < 3; i++) if (v[i] == 1'b0) z++;
    return z;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_active <= 1'b0;
      m_total  <= 0;
      m_ticks  <= 0;
      m_pulse  <= 1'b0;
    end else if (bus.clear) begin
      m_active <= 1'b0;
      m_total  <= 0;
      m_ticks  <= 0;
      m_pulse  <= 1'b0;
    end else if (bus.start && !(m_active && !fin_of(m_active, m_ticks, m_total))) begin
      m_active <= 1'b1;
      m_total  <= zeros_of(bus.CoinStatus);
      m_ticks  <= 0;
      m_pulse  <= 1'b0;
    end else if (m_active && bus.frame_tick && !fin_of(m_active, m_ticks, m_total)) begin
      m_ticks  <= m_ticks + 1;
      m_pulse  <= lit_of(m_ticks + 1, m_total) > lit_of(m_ticks, m_total);
    end else begin
      m_pulse  <= 1'b0;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      automatic bit fin = fin_of(m_active, m_ticks, m_total);
      automatic logic [7:0] exp_mask = 8'((1 << lit_of(m_ticks, m_total)) - 1);
      check("model_mask",  {5'd0, bus.star_mask},   m_active ? exp_mask : 8'd0);
      check("model_total", {6'd0, bus.stars_total}, 8'(m_total));
      check("model_pulse", {7'd0, bus.reveal_pulse}, {7'd0, m_pulse});
      check("model_busy",  {7'd0, bus.busy},  {7'd0, m_active && !fin});
      check("model_done",  {7'd0, bus.done},  {7'd0, fin});
      if (bus.reveal_pulse) pulse_cnt++;
    end
  end

  // One clock cycle with the given request inputs; returns #1 after the edge.
  task automatic step(input logic ft, input logic st, input logic cl);
    bus.frame_tick = ft;
    bus.start      = st;
    bus.clear      = cl;
    @(posedge Clk);
    #1;
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.clear      = 1'b0;
  endtask

  // n video frames, each 10 cycles with the tick in the last one.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (9) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic check_outs(input string name, input logic [2:0] mask, input logic [1:0] total,
                            input logic busy, input logic done);
    check({name, "_mask"},  {5'd0, bus.star_mask},   {5'd0, mask});
    check({name, "_total"}, {6'd0, bus.stars_total}, {6'd0, total});
    check({name, "_busy"},  {7'd0, bus.busy}, {7'd0, busy});
    check({name, "_done"},  {7'd0, bus.done}, {7'd0, done});
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.clear      = 1'b0;
    bus.CoinStatus = 3'b000;
    Reset          = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check_outs("reset", 3'b000, 2'd0, 1'b0, 1'b0);
    check("reset_pulse", {7'd0, bus.reveal_pulse}, 8'd0);
    Reset  = 1'b0;
    chk_en = 1'b1;

    // Asynchronous reset while the first star is lit.
    step(1'b0, 1'b1, 1'b0);
    frames(2);
    check("pre_reset_mask", {5'd0, bus.star_mask}, 8'h01);
    #2;
    Reset = 1'b1;
    #1;
    check_outs("async_reset", 3'b000, 2'd0, 1'b0, 1'b0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    frames(3);
    check_outs("idle_after_reset", 3'b000, 2'd0, 1'b0, 1'b0);

    // Three coins collected.
    bus.CoinStatus = 3'b000;
    pulse_cnt = 0;
    step(1'b0, 1'b1, 1'b0);
    check_outs("three_start", 3'b000, 2'd3, 1'b1, 1'b0);
    frames(2);
    check_outs("three_t2", 3'b001, 2'd3, 1'b1, 1'b0);
    check("three_t2_pulse", {7'd0, bus.reveal_pulse}, 8'd1);
    frames(3);
    check_outs("three_t5", 3'b011, 2'd3, 1'b1, 1'b0);
    frames(3);
    check_outs("three_t8", 3'b111, 2'd3, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("three_pulse_width", {7'd0, bus.reveal_pulse}, 8'd0);
    check("three_pulse_count", 8'(pulse_cnt), 8'd3);

    // Restart from DONE; start while busy and late CoinStatus changes are ignored.
    step(1'b0, 1'b1, 1'b0);
    check_outs("restart", 3'b000, 2'd3, 1'b1, 1'b0);
    frames(3);
    step(1'b0, 1'b1, 1'b0);
    frames(1);
    bus.CoinStatus = 3'b111;
    frames(4);
    check_outs("busy_latch_t8", 3'b111, 2'd3, 1'b0, 1'b1);

    // One coin collected.
    bus.CoinStatus = 3'b101;
    step(1'b0, 1'b1, 1'b0);
    check_outs("one_start", 3'b000, 2'd1, 1'b1, 1'b0);
    frames(2);
    check_outs("one_t2", 3'b001, 2'd1, 1'b0, 1'b1);
    frames(3);
    check_outs("one_later", 3'b001, 2'd1, 1'b0, 1'b1);

    // No coins collected.
    bus.CoinStatus = 3'b111;
    pulse_cnt = 0;
    step(1'b0, 1'b1, 1'b0);
    frames(1);
    check_outs("none_t1", 3'b000, 2'd0, 1'b1, 1'b0);
    frames(1);
    check_outs("none_t2", 3'b000, 2'd0, 1'b0, 1'b1);
    check("none_pulse_count", 8'(pulse_cnt), 8'd0);

    // Clear wins over a simultaneous start, then a fresh sequence.
    bus.CoinStatus = 3'b000;
    step(1'b0, 1'b1, 1'b0);
    frames(5);
    check("clear_pre_mask", {5'd0, bus.star_mask}, 8'h03);
    step(1'b0, 1'b1, 1'b1);
    check_outs("clear", 3'b000, 2'd0, 1'b0, 1'b0);
    check("clear_pulse", {7'd0, bus.reveal_pulse}, 8'd0);
    frames(2);
    check_outs("clear_idle", 3'b000, 2'd0, 1'b0, 1'b0);
    bus.CoinStatus = 3'b110;
    step(1'b0, 1'b1, 1'b0);
    check_outs("after_clear_start", 3'b000, 2'd1, 1'b1, 1'b0);
    frames(2);
    check_outs("after_clear_t2", 3'b001, 2'd1, 1'b0, 1'b1);

    // Clear together with the revealing frame tick.
    bus.CoinStatus = 3'b000;
    step(1'b0, 1'b1, 1'b0);
    frames(1);
    repeat (9) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check_outs("clear_tick", 3'b000, 2'd0, 1'b0, 1'b0);
    check("clear_tick_pulse", {7'd0, bus.reveal_pulse}, 8'd0);

    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
